// File: rtl/nessoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nessoc_pkg
//  Purpose  : Shared types and constants for the sprite DMA path and the
//             APU-side cycle bookkeeping.
//  Contents : dma_state_t  - sprite DMA sequencer states
//             c_DMA_REG_ADDR, c_OAMDATA_ADDR, c_OAM_SIZE
//  Revision : 1.0 - initial release
// ============================================================================
package nessoc_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_HALT_WAIT,
      DMA_ALIGN,
      DMA_READ,
      DMA_WRITE
   } dma_state_t;

   localparam logic [15:0] c_DMA_REG_ADDR = 16'h4014;  // CPU write here starts a DMA
   localparam logic [15:0] c_OAMDATA_ADDR = 16'h2004;  // PPU OAMDATA register
   localparam int unsigned c_OAM_SIZE     = 256;       // sprite RAM bytes

endpackage : nessoc_pkg
`default_nettype wire

// File: rtl/apu_cycle_parity.sv
`default_nettype none
// ============================================================================
//  Module   : apu_cycle_parity
//  Purpose  : Get/put cycle parity flop. Toggles on every clock from reset,
//             so parity 0 marks a get (read) cycle, parity 1 a put (write)
//             cycle. Shared by the sprite DMA and the APU frame counter.
//  Ports    : clk    in  1  clock
//             rst_n  in  1  asynchronous active-low reset (parity -> 0)
//             parity out 1  current cycle parity
//  Revision : 1.0 - initial release
// ============================================================================
module apu_cycle_parity (
   input  logic clk,
   input  logic rst_n,
   output logic parity
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
      end else begin
         parity <= ~parity;
      end
   end

endmodule : apu_cycle_parity
`default_nettype wire

// File: rtl/oam_dma_master.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_master
//  Purpose  : CPU-side sprite DMA initiator. A CPU write to DMA_REG_ADDR
//             halts the CPU and copies XFER_LEN bytes from page $XX00 to
//             OAMDATA with alternating read/write bus cycles.
//  Config   : OAMDMA_ALIGN_EN - when defined, the first read is aligned to a
//             get (parity 0) cycle; when undefined ALIGN is always 1 cycle.
//  Ports    : CPUCLK    in  1   clock
//             RST       in  1   asynchronous active-low reset
//             CPUA      in  16  CPU address (trigger decode)
//             CPUDI     in  8   CPU write data (source page)
//             RW        in  1   CPU direction, 1=read 0=write
//             CPU_RDCYC in  1   CPU is in a read cycle, halt can take hold
//             HALT      out 1   stall the CPU
//             DMA_BUSEN out 1   DMA owns the bus
//             DMA_A     out 16  DMA address
//             DMA_RW    out 1   DMA direction, 1=read 0=write
//             DMA_DO    out 8   DMA write data
//             DMA_DI    in  8   bus read data
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma_master
   import nessoc_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = c_DMA_REG_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = c_OAMDATA_ADDR,
   parameter int unsigned XFER_LEN     = c_OAM_SIZE      // power of 2, <= 256
)(
   input  logic        CPUCLK,
   input  logic        RST,
   input  logic [15:0] CPUA,
   input  logic [7:0]  CPUDI,
   input  logic        RW,
   input  logic        CPU_RDCYC,
   output logic        HALT,
   output logic        DMA_BUSEN,
   output logic [15:0] DMA_A,
   output logic        DMA_RW,
   output logic [7:0]  DMA_DO,
   input  logic [7:0]  DMA_DI
);

   localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t r_state;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic       w_parity;
   logic       w_trigger;
   logic       w_align_done;

   apu_cycle_parity u_parity (
      .clk    (CPUCLK),
      .rst_n  (RST),
      .parity (w_parity)
   );

   assign w_trigger = !RW && (CPUA == DMA_REG_ADDR);

`ifdef OAMDMA_ALIGN_EN
   // Leave ALIGN on a put cycle so the first read lands on a get cycle.
   assign w_align_done = w_parity;
`else
   logic w_unused_parity;
   assign w_unused_parity = w_parity;
   assign w_align_done    = 1'b1;
`endif

   // Sequencer. Bus outputs are set on entry to the state that uses them;
   // the byte read in READ is captured straight into DMA_DO for the put.
   always_ff @(posedge CPUCLK or negedge RST) begin
      if (!RST) begin
         r_state   <= DMA_IDLE;
         r_page    <= 8'h00;
         r_idx     <= 8'h00;
         HALT      <= 1'b0;
         DMA_BUSEN <= 1'b0;
         DMA_A     <= 16'h0000;
         DMA_RW    <= 1'b1;
         DMA_DO    <= 8'h00;
      end else begin
         case (r_state)
            DMA_IDLE: begin
               if (w_trigger) begin
                  r_page  <= CPUDI;
                  HALT    <= 1'b1;
                  r_state <= DMA_HALT_WAIT;
               end
            end
            DMA_HALT_WAIT: begin
               // The CPU only honours RDY on a read cycle.
               if (CPU_RDCYC) begin
                  DMA_BUSEN <= 1'b1;
                  DMA_RW    <= 1'b1;
                  r_state   <= DMA_ALIGN;
               end
            end
            DMA_ALIGN: begin
               if (w_align_done) begin
                  DMA_A   <= {r_page, r_idx};
                  DMA_RW  <= 1'b1;
                  r_state <= DMA_READ;
               end
            end
            DMA_READ: begin
               DMA_DO  <= DMA_DI;
               DMA_A   <= OAMDATA_ADDR;
               DMA_RW  <= 1'b0;
               r_state <= DMA_WRITE;
            end
            DMA_WRITE: begin
               if (r_idx == c_LAST_IDX) begin
                  r_idx     <= 8'h00;
                  HALT      <= 1'b0;
                  DMA_BUSEN <= 1'b0;
                  DMA_RW    <= 1'b1;
                  r_state   <= DMA_IDLE;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  DMA_A   <= {r_page, r_idx + 8'd1};
                  DMA_RW  <= 1'b1;
                  r_state <= DMA_READ;
               end
            end
            default: begin
               r_state <= DMA_IDLE;
            end
         endcase
      end
   end

endmodule : oam_dma_master
`default_nettype wire

// File: tb/tb_oam_dma_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma_master
//  Purpose  : Self-checking bench for oam_dma_master. A timeline model
//             predicts, from the trigger cycle and the first CPU_RDCYC
//             sample, which cycle each get/put of the transfer occupies and
//             what the bus must show. Directed tests pin the model with
//             literal stall lengths, addresses and data.
//  Config   : OAMDMA_ALIGN_EN selects the aligned-stall expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_master;

   localparam int c_XFER = 256;
`ifdef OAMDMA_ALIGN_EN
   localparam int c_EXP_H1 = 514;
   localparam int c_EXP_H2 = 515;
   localparam int c_EXP_H3 = 518;
`else
   localparam int c_EXP_H1 = 514;
   localparam int c_EXP_H2 = 514;
   localparam int c_EXP_H3 = 517;
`endif

   logic        CPUCLK;
   logic        RST = 1'b0;
   logic [15:0] CPUA = 16'h0000;
   logic [7:0]  CPUDI = 8'h00;
   logic        RW = 1'b1;
   logic        CPU_RDCYC = 1'b1;
   logic        HALT;
   logic        DMA_BUSEN;
   logic [15:0] DMA_A;
   logic        DMA_RW;
   logic [7:0]  DMA_DO;
   logic [7:0]  DMA_DI;

   logic [7:0]  mem [0:65535];
   assign DMA_DI = mem[DMA_A];

   oam_dma_master dut (
      .CPUCLK    (CPUCLK),
      .RST       (RST),
      .CPUA      (CPUA),
      .CPUDI     (CPUDI),
      .RW        (RW),
      .CPU_RDCYC (CPU_RDCYC),
      .HALT      (HALT),
      .DMA_BUSEN (DMA_BUSEN),
      .DMA_A     (DMA_A),
      .DMA_RW    (DMA_RW),
      .DMA_DO    (DMA_DO),
      .DMA_DI    (DMA_DI)
   );

   initial begin
      CPUCLK = 1'b0;
      forever #5 CPUCLK = ~CPUCLK;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- timeline model ----------------
   // cyc = index of the current cycle since reset release (parity = cyc%2).
   int         cyc    = 0;
   bit         m_busy = 1'b0;
   bit         m_wait = 1'b0;
   logic [7:0] m_page = 8'h00;
   int         m_r    = 0;     // cycle of the first get

   initial begin
      forever begin
         @(posedge CPUCLK or negedge RST);
         if (!RST) begin
            m_busy = 1'b0;
            m_wait = 1'b0;
            cyc    = 0;
         end else begin
            if (!m_busy) begin
               if (!RW && CPUA == 16'h4014) begin
                  m_busy = 1'b1;
                  m_wait = 1'b1;
                  m_page = CPUDI;
               end
            end else if (m_wait) begin
               if (CPU_RDCYC) begin
                  int a;
                  m_wait = 1'b0;
                  a = cyc + 1;
`ifdef OAMDMA_ALIGN_EN
                  m_r = (a % 2 == 1) ? a + 1 : a + 2;
`else
                  m_r = a + 1;
`endif
               end
            end else if (cyc + 1 == m_r + 2 * c_XFER) begin
               m_busy = 1'b0;
            end
            cyc++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [15:0] log_rd [$];
   logic [7:0]  log_do [$];
   logic [15:0] prev_a    = 16'h0000;
   int          halt_cnt  = 0;
   int          last_halt = 0;

   initial begin
      forever begin
         @(negedge CPUCLK);
         if (!RST) begin
            halt_cnt = 0;
            chk("rst_halt",  HALT, 0);
            chk("rst_busen", DMA_BUSEN, 0);
            chk("rst_a",     DMA_A, 0);
            chk("rst_rw",    DMA_RW, 1);
            chk("rst_do",    DMA_DO, 0);
         end else begin
            logic        e_halt, e_bus, e_rw, e_has_a, e_has_do;
            logic [15:0] e_a;
            logic [7:0]  e_do;
            e_halt = 0; e_bus = 0; e_rw = 1; e_has_a = 0; e_has_do = 0;
            e_a = 16'h0; e_do = 8'h0;
            if (m_busy) begin
               e_halt = 1;
               if (!m_wait) begin
                  e_bus = 1;
                  if (cyc >= m_r) begin
                     int j, b;
                     j = cyc - m_r;
                     b = j / 2;
                     e_has_a = 1;
                     if (j % 2 == 0) begin
                        e_a = {m_page, 8'(b)};
                     end else begin
                        e_rw     = 0;
                        e_a      = 16'h2004;
                        e_has_do = 1;
                        e_do     = mem[{m_page, 8'(b)}];
                     end
                  end
               end
            end
            chk("halt",  HALT, e_halt);
            chk("busen", DMA_BUSEN, e_bus);
            chk("rw",    DMA_RW, e_rw);
            if (e_has_a)  chk("addr", DMA_A, e_a);
            if (e_has_do) chk("wdata", DMA_DO, e_do);
            if (DMA_BUSEN && !DMA_RW) begin
               log_do.push_back(DMA_DO);
               log_rd.push_back(prev_a);
            end
            if (HALT) begin
               halt_cnt++;
            end else if (halt_cnt != 0) begin
               last_halt = halt_cnt;
               halt_cnt  = 0;
            end
         end
         prev_a = DMA_A;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic trig(input logic [7:0] pg, input int par, input bit stall);
      int n = 0;
      last_halt = 0;
      log_rd.delete();
      log_do.delete();
      @(negedge CPUCLK);
      while ((cyc % 2) != par && n < 4) begin
         @(negedge CPUCLK);
         n++;
      end
      CPUA = 16'h4014; RW = 1'b0; CPUDI = pg;
      if (stall) CPU_RDCYC = 1'b0;
      @(negedge CPUCLK);
      RW = 1'b1; CPUA = 16'h0000;
      if (stall) begin
         repeat (3) @(negedge CPUCLK);
         CPU_RDCYC = 1'b1;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!HALT && n < 50) begin @(negedge CPUCLK); n++; end
      while (HALT && n < 3000) begin @(negedge CPUCLK); n++; end
      chk("xfer_done_in_budget", HALT, 0);
      repeat (2) @(negedge CPUCLK);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8);

      repeat (3) @(negedge CPUCLK);
      chk("reset_halt", HALT, 0);
      chk("reset_a", DMA_A, 0);
      #2 RST = 1'b1;

      // 1: page $02, trigger on a put cycle
      trig(8'h02, 1, 1'b0);
      wait_done();
      chk("t1_halt_len", last_halt, c_EXP_H1);
      chk("t1_count", log_do.size(), 256);
      chk("t1_first_rd", log_rd[0], 16'h0200);
      chk("t1_last_rd", log_rd[255], 16'h02FF);
      chk("t1_do5", log_do[5], 8'h07);
      chk("t1_do255", log_do[255], 8'hFD);

      // 2: trigger on a get cycle
      trig(8'h02, 0, 1'b0);
      wait_done();
      chk("t2_halt_len", last_halt, c_EXP_H2);

      // 3: CPU not in a read cycle for 3 cycles after trigger
      trig(8'h02, 1, 1'b1);
      wait_done();
      chk("t3_halt_len", last_halt, c_EXP_H3);
      chk("t3_count", log_do.size(), 256);

      // 4: page $07 = i^$A5
      for (int i = 0; i < 256; i++) mem[{8'h07, 8'(i)}] = 8'(i) ^ 8'hA5;
      trig(8'h07, 1, 1'b0);
      wait_done();
      chk("t4_count", log_do.size(), 256);
      chk("t4_do0", log_do[0], 8'hA5);
      chk("t4_do255", log_do[255], 8'h5A);
      begin
         int bad = 0;
         for (int i = 0; i < log_do.size(); i++) begin
            if (log_do[i] != (8'(i) ^ 8'hA5) || log_rd[i] > 16'h07FF) bad++;
         end
         chk("t4_sequence_errors", bad, 0);
      end

      // 5: second trigger mid-transfer is ignored
      trig(8'h02, 1, 1'b0);
      repeat (50) @(negedge CPUCLK);
      CPUA = 16'h4014; RW = 1'b0; CPUDI = 8'h03;
      @(negedge CPUCLK);
      RW = 1'b1; CPUA = 16'h0000;
      wait_done();
      chk("t5_halt_len", last_halt, c_EXP_H1);
      begin
         int bad = 0;
         for (int i = 0; i < log_rd.size(); i++) if (log_rd[i][15:8] != 8'h02) bad++;
         chk("t5_off_page_reads", bad, 0);
      end

      // 5b: trigger sampled on the cycle the block returns to idle
      trig(8'h02, 1, 1'b0);
      begin
         int n = 0;
         while (!(m_busy && !m_wait && cyc == m_r + 2 * c_XFER - 1) && n < 2000) begin
            @(negedge CPUCLK);
            n++;
         end
         chk("t5b_end_cycle_reached", cyc, m_r + 2 * c_XFER - 1);
      end
      CPUA = 16'h4014; RW = 1'b0; CPUDI = 8'h05;
      @(negedge CPUCLK);
      RW = 1'b1; CPUA = 16'h0000;
      repeat (3) @(negedge CPUCLK);
      chk("t5b_no_restart", HALT, 0);

      // 6: reset at byte 100, then a clean transfer from page $01
      trig(8'h02, 1, 1'b0);
      begin
         int n = 0;
         while (log_do.size() < 100 && n < 2000) begin @(negedge CPUCLK); n++; end
         chk("t6_byte100_reached", log_do.size(), 100);
      end
      #2 RST = 1'b0;
      #1;
      chk("t6_halt", HALT, 0);
      chk("t6_busen", DMA_BUSEN, 0);
      chk("t6_a", DMA_A, 0);
      chk("t6_rw", DMA_RW, 1);
      chk("t6_do", DMA_DO, 0);
      @(negedge CPUCLK);
      #2 RST = 1'b1;
      trig(8'h01, 1, 1'b0);
      wait_done();
      chk("t6_count", log_do.size(), 256);
      chk("t6_first_rd", log_rd[0], 16'h0100);
      chk("t6_do16", log_do[16], 8'h11);
      chk("t6_halt_len", last_halt, c_EXP_H1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_oam_dma_master
`default_nettype wire
